// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, bubble, flush and forwarding control for the 5-stage core
// Handles cache-miss waits, load-use interlocks and redirects during fetch misses.
module hazard_ctrl #(
  parameter int LOAD_USE_CYCLES = 1,
  parameter bit FWD_EN          = 1'b1,
  parameter int CNT_W           = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_valid,
  input  logic [6:0]       i_id_opcode,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_regwrite,
  input  logic             i_ex_memread,
  input  logic [4:0]       i_mem_rd,
  input  logic             i_mem_regwrite,
  input  logic             i_ex_redirect,
  input  logic             i_imem_ren,
  input  logic             i_imem_ready,
  input  logic             i_dmem_ren,
  input  logic             i_dmem_wen,
  input  logic             i_dmem_ready,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_en,
  output logic             o_id_ex_bubble,
  output logic             o_back_en,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_istall_cnt,
  output logic [CNT_W-1:0] o_dstall_cnt,
  output logic [CNT_W-1:0] o_lu_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    IWAIT = 2'b01,
    DWAIT = 2'b10
  } state_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [2:0] LU_INIT  = 3'(LOAD_USE_CYCLES - 1);

  state_t     state;
  logic [2:0] lu_cnt;
  logic       flush_pend;

  logic istall, dstall, redirect;
  logic use_rs1, use_rs2;
  logic ex_m1, ex_m2, mem_m1, mem_m2;
  logic ex_hit, mem_hit;
  logic lu_hit, raw_hit, lu_hold;
  logic [1:0] sel_a, sel_b;

  assign istall   = i_imem_ren & ~i_imem_ready;
  assign dstall   = (i_dmem_ren | i_dmem_wen) & ~i_dmem_ready;
  assign redirect = i_ex_redirect & ~dstall;

  assign use_rs1 = !(i_id_opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign use_rs2 = i_id_opcode inside {OP_R, OP_S, OP_B};

  assign ex_m1 = i_id_valid & use_rs1 & (i_ex_rd != 5'd0)
               & (i_ex_rd == i_id_rs1);
  assign ex_m2 = i_id_valid & use_rs2 & (i_ex_rd != 5'd0)
               & (i_ex_rd == i_id_rs2);
  assign mem_m1 = i_id_valid & use_rs1 & (i_mem_rd != 5'd0)
                & (i_mem_rd == i_id_rs1);
  assign mem_m2 = i_id_valid & use_rs2 & (i_mem_rd != 5'd0)
                & (i_mem_rd == i_id_rs2);

  assign ex_hit  = ex_m1 | ex_m2;
  assign mem_hit = mem_m1 | mem_m2;
  assign lu_hit  = ex_hit & i_ex_memread;
  assign raw_hit = !FWD_EN & ((ex_hit & i_ex_regwrite)
                 | (mem_hit & i_mem_regwrite));
  assign lu_hold = lu_hit | (lu_cnt != 3'd0) | raw_hit;

  function automatic logic [1:0] pick(input logic ex_m,
                                      input logic mem_m,
                                      input logic ex_wr,
                                      input logic ex_rd_mem,
                                      input logic mem_wr);
    if (!FWD_EN) return 2'b00;
    if (ex_m & ex_wr & ~ex_rd_mem) return 2'b01;
    if (mem_m & mem_wr) return 2'b10;
    return 2'b00;
  endfunction

  assign sel_a = pick(ex_m1, mem_m1, i_ex_regwrite,
                      i_ex_memread, i_mem_regwrite);
  assign sel_b = pick(ex_m2, mem_m2, i_ex_regwrite,
                      i_ex_memread, i_mem_regwrite);

  // Zero-latency pipeline enables: dstall > redirect > istall/load-use.
  always_comb begin
    o_pc_en        = 1'b1;
    o_if_id_en     = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_en     = 1'b1;
    o_id_ex_bubble = 1'b0;
    o_back_en      = 1'b1;
    if (dstall) begin
      o_pc_en    = 1'b0;
      o_if_id_en = 1'b0;
      o_id_ex_en = 1'b0;
      o_back_en  = 1'b0;
    end else if (redirect) begin
      o_if_id_flush  = 1'b1;
      o_id_ex_bubble = 1'b1;
    end else begin
      if (istall | lu_hold) begin
        o_pc_en        = 1'b0;
        o_if_id_en     = 1'b0;
        o_id_ex_bubble = 1'b1;
      end
      if (flush_pend & ~istall) o_if_id_flush = 1'b1;
    end
  end

  // Miss-wait FSM; state is the registered output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= RUN;
    end else if (dstall) begin
      state <= DWAIT;
    end else if (istall) begin
      state <= IWAIT;
    end else begin
      state <= RUN;
    end
  end

  assign o_state = state;

  // Load-use bubble counter, frozen while the back end is stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lu_cnt <= 3'd0;
    end else if (!dstall) begin
      if (i_ex_redirect) lu_cnt <= 3'd0;
      else if (lu_cnt != 3'd0) lu_cnt <= lu_cnt - 3'd1;
      else if (lu_hit) lu_cnt <= LU_INIT;
    end
  end

  // Remember a redirect taken while the fetch is still outstanding.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      flush_pend <= 1'b0;
    end else if (!dstall) begin
      if (redirect & istall) flush_pend <= 1'b1;
      else if (!istall) flush_pend <= 1'b0;
    end
  end

  // Forwarding selects follow the instruction into EX.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fwd_a <= 2'b00;
      o_fwd_b <= 2'b00;
    end else if (o_id_ex_en) begin
      if (o_id_ex_bubble) begin
        o_fwd_a <= 2'b00;
        o_fwd_b <= 2'b00;
      end else begin
        o_fwd_a <= sel_a;
        o_fwd_b <= sel_b;
      end
    end
  end

  // Saturating stall-cycle counters, one cause per cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_istall_cnt <= '0;
      o_dstall_cnt <= '0;
      o_lu_cnt     <= '0;
    end else if (dstall) begin
      if (o_dstall_cnt != '1) o_dstall_cnt <= o_dstall_cnt + 1'b1;
    end else if (istall) begin
      if (o_istall_cnt != '1) o_istall_cnt <= o_istall_cnt + 1'b1;
    end else if (!i_ex_redirect & lu_hold) begin
      if (o_lu_cnt != '1) o_lu_cnt <= o_lu_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: random stimulus against a behavioural model, two configs
// Expected responses are queued by the driver and checked by a monitor.
module tb_hazard_ctrl;

  localparam int NCYC = 4000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       id_valid, ex_regwrite, ex_memread, mem_regwrite;
  logic [6:0] opcode;
  logic [4:0] rs1, rs2, ex_rd, mem_rd;
  logic       redirect, imem_ren, imem_ready;
  logic       dmem_ren, dmem_wen, dmem_ready;

  logic        a_pc, a_ifid, a_fl, a_idex, a_bub, a_back;
  logic [1:0]  a_fa, a_fb, a_st;
  logic [31:0] a_ci, a_cd, a_cl;
  logic        b_pc, b_ifid, b_fl, b_idex, b_bub, b_back;
  logic [1:0]  b_fa, b_fb, b_st;
  logic [3:0]  b_ci, b_cd, b_cl;

  hazard_ctrl #(.LOAD_USE_CYCLES(3), .FWD_EN(1'b1), .CNT_W(32)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
    .i_id_opcode(opcode), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_ex_rd(ex_rd), .i_ex_regwrite(ex_regwrite),
    .i_ex_memread(ex_memread), .i_mem_rd(mem_rd),
    .i_mem_regwrite(mem_regwrite), .i_ex_redirect(redirect),
    .i_imem_ren(imem_ren), .i_imem_ready(imem_ready),
    .i_dmem_ren(dmem_ren), .i_dmem_wen(dmem_wen),
    .i_dmem_ready(dmem_ready),
    .o_pc_en(a_pc), .o_if_id_en(a_ifid), .o_if_id_flush(a_fl),
    .o_id_ex_en(a_idex), .o_id_ex_bubble(a_bub), .o_back_en(a_back),
    .o_fwd_a(a_fa), .o_fwd_b(a_fb), .o_state(a_st),
    .o_istall_cnt(a_ci), .o_dstall_cnt(a_cd), .o_lu_cnt(a_cl)
  );

  hazard_ctrl #(.LOAD_USE_CYCLES(1), .FWD_EN(1'b0), .CNT_W(4)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
    .i_id_opcode(opcode), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_ex_rd(ex_rd), .i_ex_regwrite(ex_regwrite),
    .i_ex_memread(ex_memread), .i_mem_rd(mem_rd),
    .i_mem_regwrite(mem_regwrite), .i_ex_redirect(redirect),
    .i_imem_ren(imem_ren), .i_imem_ready(imem_ready),
    .i_dmem_ren(dmem_ren), .i_dmem_wen(dmem_wen),
    .i_dmem_ready(dmem_ready),
    .o_pc_en(b_pc), .o_if_id_en(b_ifid), .o_if_id_flush(b_fl),
    .o_id_ex_en(b_idex), .o_id_ex_bubble(b_bub), .o_back_en(b_back),
    .o_fwd_a(b_fa), .o_fwd_b(b_fb), .o_state(b_st),
    .o_istall_cnt(b_ci), .o_dstall_cnt(b_cd), .o_lu_cnt(b_cl)
  );

  typedef struct {
    logic [5:0] en;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] st;
    longint     ci;
    longint     cd;
    longint     cl;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Model configuration and state: index 0 = u_a, 1 = u_b
  int     cfg_n[2]  = '{3, 1};
  bit     cfg_f[2]  = '{1'b1, 1'b0};
  longint cfg_mx[2] = '{64'hFFFF_FFFF, 64'hF};

  int         st[2], lc[2], n_st[2], n_lc[2];
  bit         fp[2], n_fp[2];
  logic [1:0] fa[2], fb[2], n_fa[2], n_fb[2];
  longint     ci[2], cd[2], cl[2], n_ci[2], n_cd[2], n_cl[2];

  logic [6:0] ops[8] = '{7'b0110111, 7'b0010111, 7'b1101111,
                         7'b0110011, 7'b0100011, 7'b1100011,
                         7'b0010011, 7'b0000011};

  task automatic check(input string nm, input longint act,
                       input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic bit src_hit(input logic [4:0] rd,
                                 input logic [4:0] rs, input bit u);
    return id_valid && u && rd != 5'd0 && rd == rs;
  endfunction

  task automatic model_reset(input int c);
    st[c] = 0; lc[c] = 0; fp[c] = 0;
    fa[c] = 2'b00; fb[c] = 2'b00;
    ci[c] = 0; cd[c] = 0; cl[c] = 0;
  endtask

  task automatic model_apply(input int c);
    st[c] = n_st[c]; lc[c] = n_lc[c]; fp[c] = n_fp[c];
    fa[c] = n_fa[c]; fb[c] = n_fb[c];
    ci[c] = n_ci[c]; cd[c] = n_cd[c]; cl[c] = n_cl[c];
  endtask

  // Reference model: what the pipeline should see this cycle and next.
  task automatic model_eval(input int c, output exp_t e);
    bit is, ds, rd, u1, u2, x1, x2, m1, m2, lu, raw, hold;
    bit pc, ifid, fl, idex, bub, back;
    int s1, s2;
    is = imem_ren && !imem_ready;
    ds = (dmem_ren || dmem_wen) && !dmem_ready;
    rd = redirect && !ds;
    u1 = !(opcode == 7'b0110111 || opcode == 7'b0010111
           || opcode == 7'b1101111);
    u2 = opcode == 7'b0110011 || opcode == 7'b0100011
         || opcode == 7'b1100011;
    x1 = src_hit(ex_rd, rs1, u1);
    x2 = src_hit(ex_rd, rs2, u2);
    m1 = src_hit(mem_rd, rs1, u1);
    m2 = src_hit(mem_rd, rs2, u2);
    lu = (x1 || x2) && ex_memread;
    raw = !cfg_f[c] && (((x1 || x2) && ex_regwrite)
          || ((m1 || m2) && mem_regwrite));
    hold = lu || lc[c] != 0 || raw;

    if (ds) begin
      {pc, ifid, fl, idex, bub, back} = 6'b000000;
    end else if (rd) begin
      {pc, ifid, fl, idex, bub, back} = 6'b111111;
    end else begin
      idex = 1; back = 1;
      pc = !(is || hold); ifid = pc; bub = !pc;
      fl = fp[c] && !is;
    end
    e.en = {pc, ifid, fl, idex, bub, back};
    e.fa = fa[c]; e.fb = fb[c];
    e.st = st[c][1:0];
    e.ci = ci[c]; e.cd = cd[c]; e.cl = cl[c];

    n_st[c] = ds ? 2 : (is ? 1 : 0);
    if (ds) n_lc[c] = lc[c];
    else if (redirect) n_lc[c] = 0;
    else if (lc[c] != 0) n_lc[c] = lc[c] - 1;
    else if (lu) n_lc[c] = cfg_n[c] - 1;
    else n_lc[c] = 0;

    n_fp[c] = fp[c];
    if (!ds) begin
      if (rd && is) n_fp[c] = 1;
      else if (!is) n_fp[c] = 0;
    end

    s1 = 0; s2 = 0;
    if (cfg_f[c]) begin
      if (x1 && ex_regwrite && !ex_memread) s1 = 1;
      else if (m1 && mem_regwrite) s1 = 2;
      if (x2 && ex_regwrite && !ex_memread) s2 = 1;
      else if (m2 && mem_regwrite) s2 = 2;
    end
    n_fa[c] = fa[c]; n_fb[c] = fb[c];
    if (idex) begin
      n_fa[c] = bub ? 2'd0 : 2'(s1);
      n_fb[c] = bub ? 2'd0 : 2'(s2);
    end

    n_ci[c] = ci[c]; n_cd[c] = cd[c]; n_cl[c] = cl[c];
    if (ds) n_cd[c] = (cd[c] < cfg_mx[c]) ? cd[c] + 1 : cd[c];
    else if (is) n_ci[c] = (ci[c] < cfg_mx[c]) ? ci[c] + 1 : ci[c];
    else if (!redirect && hold)
      n_cl[c] = (cl[c] < cfg_mx[c]) ? cl[c] + 1 : cl[c];
  endtask

  task automatic randomize_inputs();
    id_valid     = $urandom_range(0, 9) != 0;
    opcode       = ops[$urandom_range(0, 7)];
    rs1          = 5'($urandom_range(0, 3));
    rs2          = 5'($urandom_range(0, 3));
    ex_rd        = 5'($urandom_range(0, 3));
    mem_rd       = 5'($urandom_range(0, 3));
    ex_regwrite  = $urandom_range(0, 3) != 0;
    ex_memread   = $urandom_range(0, 2) == 0;
    mem_regwrite = $urandom_range(0, 3) != 0;
    redirect     = $urandom_range(0, 9) == 0;
    imem_ren     = $urandom_range(0, 1) == 1;
    imem_ready   = $urandom_range(0, 4) < 3;
    dmem_ren     = $urandom_range(0, 4) == 0;
    dmem_wen     = $urandom_range(0, 6) == 0;
    dmem_ready   = $urandom_range(0, 1) == 1;
  endtask

  // Driver: apply inputs, push expected responses, advance the model.
  initial begin
    exp_t e0, e1;
    rst_n = 1'b0;
    randomize_inputs();
    model_reset(0);
    model_reset(1);
    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      randomize_inputs();
      rst_n = (i >= 3) && ($urandom_range(0, 299) != 0);
      #1;
      if (!rst_n) begin
        model_reset(0);
        model_reset(1);
      end
      model_eval(0, e0);
      model_eval(1, e1);
      q0.push_back(e0);
      q1.push_back(e1);
      @(posedge clk);
      if (rst_n) begin
        model_apply(0);
        model_apply(1);
      end
    end
    @(negedge clk);
    #5;
    check("queue_drain_a", q0.size(), 0);
    check("queue_drain_b", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  // Monitor: compare both instances against the queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("a_enables", {a_pc, a_ifid, a_fl, a_idex, a_bub, a_back},
              e.en);
        check("a_fwd_a", a_fa, e.fa);
        check("a_fwd_b", a_fb, e.fb);
        check("a_state", a_st, e.st);
        check("a_istall_cnt", a_ci, e.ci);
        check("a_dstall_cnt", a_cd, e.cd);
        check("a_lu_cnt", a_cl, e.cl);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("b_enables", {b_pc, b_ifid, b_fl, b_idex, b_bub, b_back},
              e.en);
        check("b_fwd_a", b_fa, e.fa);
        check("b_fwd_b", b_fb, e.fb);
        check("b_state", b_st, e.st);
        check("b_istall_cnt", b_ci, e.ci);
        check("b_dstall_cnt", b_cd, e.cd);
        check("b_lu_cnt", b_cl, e.cl);
      end
    end
  end

endmodule
